// File: rtl/elev_pkg.sv
// elev_pkg: shared direction encodings and call-class indices for the elevator controller
package elev_pkg;
  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;
  typedef enum logic [1:0] {CLS_CAR, CLS_UP, CLS_DN} call_cls_e;
endpackage

// File: rtl/call_request_board_if.sv
// call_request_board_if: button pulses, car position and latched call status of the request board
interface call_request_board_if #(parameter int N_FLOORS = 4);
  localparam int FLOOR_W = $clog2(N_FLOORS);
  localparam int CNT_W   = $clog2(3 * N_FLOORS + 1);
  logic [N_FLOORS-1:0] car_set, up_set, dn_set, car_cancel;
  logic [N_FLOORS-1:0] car_req, up_req, dn_req, aged;
  logic [FLOOR_W-1:0]  cur_floor;
  logic [1:0]          dir;
  logic                arrive, age_tick, any_above, any_below, any_at;
  logic [CNT_W-1:0]    pending_cnt;
  modport master (
    output car_set, up_set, dn_set, car_cancel, cur_floor, dir, arrive, age_tick,
    input  car_req, up_req, dn_req, aged, any_above, any_below, any_at, pending_cnt
  );
  modport slave (
    input  car_set, up_set, dn_set, car_cancel, cur_floor, dir, arrive, age_tick,
    output car_req, up_req, dn_req, aged, any_above, any_below, any_at, pending_cnt
  );
endinterface

// File: rtl/req_age_counter.sv
// req_age_counter: saturating wait-time counter for one floor's hall call
module req_age_counter #(
  parameter int AGE_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic tick,
  output logic aged
);
  localparam int W = $clog2(AGE_MAX + 1);
  localparam logic [W-1:0] MAX = W'(AGE_MAX);
  logic [W-1:0] cnt_q, cnt_d;
  logic aged_q, aged_d;
  // restart whenever no hall call is waiting, otherwise count ticks up to saturation
  always_comb begin
    cnt_d = !active ? '0 : tick && cnt_q != MAX ? cnt_q + 1'b1 : cnt_q;
    aged_d = active && cnt_d == MAX;
  end
  // counter and flag registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      aged_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      aged_q <= aged_d;
    end
  assign aged = aged_q;
endmodule

// File: rtl/call_request_board.sv
// call_request_board: per-floor car/hall call latches with service clear, summaries and aging
module call_request_board
  import elev_pkg::*;
#(
  parameter int N_FLOORS = 4,
  parameter int AGE_MAX  = 15
) (
  input logic clk,
  input logic rst_n,
  call_request_board_if.slave bus
);
  localparam int FLOOR_W = $clog2(N_FLOORS);
  localparam int CNT_W   = $clog2(3 * N_FLOORS + 1);
  localparam logic [N_FLOORS-1:0] UP_OK = {1'b0, {(N_FLOORS-1){1'b1}}};
  localparam logic [N_FLOORS-1:0] DN_OK = {{(N_FLOORS-1){1'b1}}, 1'b0};
  logic [2:0][N_FLOORS-1:0] req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_FLOORS-1:0] hit, all_q;
  logic [FLOOR_W-1:0] f;
  logic in_range, above, below, at;
  assign f = bus.cur_floor;
  assign in_range = int'(f) < N_FLOORS;
  // next call state per class: service clear beats cancel beats set beats hold
  always_comb begin
    hit = in_range && bus.arrive ? N_FLOORS'(1) << f : '0;
    req_d[CLS_CAR] = ~hit & ~bus.car_cancel & (req_q[CLS_CAR] | bus.car_set);
    req_d[CLS_UP] = ~(bus.dir != DIR_DN ? hit : '0) & (req_q[CLS_UP] | bus.up_set) & UP_OK;
    req_d[CLS_DN] = ~(bus.dir != DIR_UP ? hit : '0) & (req_q[CLS_DN] | bus.dn_set) & DN_OK;
    cnt_d = '0;
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < N_FLOORS; i++)
        cnt_d += CNT_W'(req_d[c][i]);
  end
  // summaries relative to the car; an unknown floor reports every call as above
  always_comb begin
    all_q = req_q[CLS_CAR] | req_q[CLS_UP] | req_q[CLS_DN];
    above = 1'b0;
    below = 1'b0;
    at = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      above |= all_q[i] & (!in_range | (i > int'(f)));
      below |= all_q[i] & in_range & (i < int'(f));
      at |= all_q[i] & (i == int'(f));
    end
  end
  // call latches and pending count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      req_q <= '0;
      cnt_q <= '0;
    end else begin
      req_q <= req_d;
      cnt_q <= cnt_d;
    end
  for (genvar i = 0; i < N_FLOORS; i++) begin : g_age
    req_age_counter #(.AGE_MAX(AGE_MAX)) u_age (
      .clk   (clk),
      .rst_n (rst_n),
      .active(req_q[CLS_UP][i] | req_q[CLS_DN][i]),
      .tick  (bus.age_tick),
      .aged  (bus.aged[i])
    );
  end
  assign bus.car_req = req_q[CLS_CAR];
  assign bus.up_req = req_q[CLS_UP];
  assign bus.dn_req = req_q[CLS_DN];
  assign bus.pending_cnt = cnt_q;
  assign bus.any_above = above;
  assign bus.any_below = below;
  assign bus.any_at = at;
endmodule

// File: tb/tb_call_request_board.sv
// tb_call_request_board: directed and random checks of two board sizes against a floor-by-floor call model
module tb_call_request_board;
  localparam int AGE = 3;
  logic clk, rst_n;
  logic [4:0] cs, us, ds, cc;
  logic [1:0] cf4, dr;
  logic [2:0] cf5;
  logic arr, tk;
  int ncmp, nfail;
  bit mcar[2][5], mup[2][5], mdn[2][5], maged[2][5];
  int mage[2][5];

  call_request_board_if #(.N_FLOORS(4)) i4 ();
  call_request_board_if #(.N_FLOORS(5)) i5 ();
  call_request_board #(.N_FLOORS(4), .AGE_MAX(AGE)) d4 (.clk(clk), .rst_n(rst_n), .bus(i4));
  call_request_board #(.N_FLOORS(5), .AGE_MAX(AGE)) d5 (.clk(clk), .rst_n(rst_n), .bus(i5));

  assign i4.car_set = cs[3:0];
  assign i4.up_set = us[3:0];
  assign i4.dn_set = ds[3:0];
  assign i4.car_cancel = cc[3:0];
  assign i4.cur_floor = cf4;
  assign i4.dir = dr;
  assign i4.arrive = arr;
  assign i4.age_tick = tk;
  assign i5.car_set = cs;
  assign i5.up_set = us;
  assign i5.dn_set = ds;
  assign i5.car_cancel = cc;
  assign i5.cur_floor = cf5;
  assign i5.dir = dr;
  assign i5.arrive = arr;
  assign i5.age_tick = tk;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 5; i++) begin
        mcar[k][i] = 0; mup[k][i] = 0; mdn[k][i] = 0; maged[k][i] = 0; mage[k][i] = 0;
      end
  endtask

  // one clock edge of the call board as described floor by floor
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int n, fl;
      n = k ? 5 : 4;
      fl = k ? int'(cf5) : int'(cf4);
      for (int i = 0; i < n; i++) begin
        bit hall, srv;
        hall = mup[k][i] | mdn[k][i];
        srv = arr && fl == i;
        if (!hall) mage[k][i] = 0;
        else if (tk && mage[k][i] < AGE) mage[k][i]++;
        maged[k][i] = hall && mage[k][i] == AGE;
        if (srv || cc[i]) mcar[k][i] = 0; else if (cs[i]) mcar[k][i] = 1;
        if (srv && dr != 2'b10) mup[k][i] = 0; else if (us[i] && i != n - 1) mup[k][i] = 1;
        if (srv && dr != 2'b01) mdn[k][i] = 0; else if (ds[i] && i != 0) mdn[k][i] = 1;
      end
    end
  endtask

  function automatic logic [31:0] vec(input int k, input int c);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < (k ? 5 : 4); i++)
      v[i] = c == 0 ? mcar[k][i] : c == 1 ? mup[k][i] : c == 2 ? mdn[k][i] : maged[k][i];
    return v;
  endfunction

  // w: 0 above, 1 below, 2 at, 3 number of calls
  function automatic logic [31:0] summ(input int k, input int w);
    int n, fl, ab, be, at, cnt;
    n = k ? 5 : 4;
    fl = k ? int'(cf5) : int'(cf4);
    ab = 0; be = 0; at = 0; cnt = 0;
    for (int i = 0; i < n; i++) begin
      int c;
      c = int'(mcar[k][i]) + int'(mup[k][i]) + int'(mdn[k][i]);
      cnt += c;
      if (c > 0 && (fl >= n || i > fl)) ab = 1;
      if (c > 0 && fl < n && i < fl) be = 1;
      if (c > 0 && i == fl) at = 1;
    end
    return w == 0 ? ab : w == 1 ? be : w == 2 ? at : cnt;
  endfunction

  task automatic check_all();
    chk("car_req4", 32'(i4.car_req), vec(0, 0));
    chk("up_req4", 32'(i4.up_req), vec(0, 1));
    chk("dn_req4", 32'(i4.dn_req), vec(0, 2));
    chk("aged4", 32'(i4.aged), vec(0, 3));
    chk("above4", 32'(i4.any_above), summ(0, 0));
    chk("below4", 32'(i4.any_below), summ(0, 1));
    chk("at4", 32'(i4.any_at), summ(0, 2));
    chk("pending4", 32'(i4.pending_cnt), summ(0, 3));
    chk("car_req5", 32'(i5.car_req), vec(1, 0));
    chk("up_req5", 32'(i5.up_req), vec(1, 1));
    chk("dn_req5", 32'(i5.dn_req), vec(1, 2));
    chk("aged5", 32'(i5.aged), vec(1, 3));
    chk("above5", 32'(i5.any_above), summ(1, 0));
    chk("below5", 32'(i5.any_below), summ(1, 1));
    chk("at5", 32'(i5.any_at), summ(1, 2));
    chk("pending5", 32'(i5.pending_cnt), summ(1, 3));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    cs = '0; us = '0; ds = '0; cc = '0; arr = 1'b0; tk = 1'b0;
  endtask

  task automatic floor(input int fl);
    cf4 = 2'(fl);
    cf5 = 3'(fl);
  endtask

  task automatic serve_all();
    dr = 2'b00;
    for (int fl = 0; fl < 5; fl++) begin
      floor(fl);
      arr = 1'b1;
      step();
    end
  endtask

  initial begin
    ncmp = 0; nfail = 0;
    cs = '0; us = '0; ds = '0; cc = '0; cf4 = '0; cf5 = '0; dr = '0; arr = 0; tk = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk) rst_n = 1'b1;
    // asynchronous reset in the middle of operation
    cs = 5'b01010;
    step();
    chk("latch1010", 32'(i4.car_req), 32'h0a);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_car", 32'(i4.car_req), 32'h0);
    chk("async_cnt", 32'(i4.pending_cnt), 32'h0);
    check_all();
    @(negedge clk) rst_n = 1'b1;
    // set, then serve a hall-up call
    cs[2] = 1'b1; us[1] = 1'b1; floor(0); dr = 2'b01;
    step();
    chk("set_car", 32'(i4.car_req), 32'h4);
    chk("set_up", 32'(i4.up_req), 32'h2);
    chk("set_above", 32'(i4.any_above), 32'h1);
    chk("set_cnt", 32'(i4.pending_cnt), 32'h2);
    floor(1); arr = 1'b1;
    step();
    chk("srv_up", 32'(i4.up_req), 32'h0);
    chk("srv_car", 32'(i4.car_req), 32'h4);
    chk("srv_cnt", 32'(i4.pending_cnt), 32'h1);
    serve_all();
    // direction qualification
    us[2] = 1'b1; ds[2] = 1'b1;
    step();
    floor(2); dr = 2'b10; arr = 1'b1;
    step();
    chk("qual_dn_up", 32'(i4.up_req), 32'h4);
    chk("qual_dn_dn", 32'(i4.dn_req), 32'h0);
    ds[2] = 1'b1;
    step();
    dr = 2'b00; arr = 1'b1;
    step();
    chk("qual_idle_up", 32'(i4.up_req), 32'h0);
    chk("qual_idle_dn", 32'(i4.dn_req), 32'h0);
    // collisions
    floor(3); arr = 1'b1; cs[3] = 1'b1; ds[3] = 1'b1;
    step();
    chk("coll_car", 32'(i4.car_req), 32'h0);
    chk("coll_dn", 32'(i4.dn_req), 32'h0);
    dr = 2'b01; floor(2); arr = 1'b1; ds[2] = 1'b1;
    step();
    chk("coll_unqual_dn", 32'(i4.dn_req), 32'h4);
    cs[1] = 1'b1; cc[1] = 1'b1;
    step();
    chk("cancel_set", 32'(i4.car_req), 32'h0);
    serve_all();
    // physical boundaries
    us[3] = 1'b1; ds[0] = 1'b1;
    step();
    chk("bound_up", 32'(i4.up_req), 32'h0);
    chk("bound_dn", 32'(i4.dn_req), 32'h0);
    chk("bound_cnt", 32'(i4.pending_cnt), 32'h0);
    serve_all();
    // out-of-range floor on the five-floor board
    cs[0] = 1'b1; us[2] = 1'b1; dr = 2'b00;
    step();
    cf5 = 3'd5; arr = 1'b1;
    step();
    chk("oor_car", 32'(i5.car_req), 32'h01);
    chk("oor_up", 32'(i5.up_req), 32'h04);
    chk("oor_above", 32'(i5.any_above), 32'h1);
    chk("oor_at", 32'(i5.any_at), 32'h0);
    chk("oor_below", 32'(i5.any_below), 32'h0);
    serve_all();
    // aging
    us[1] = 1'b1; floor(0); dr = 2'b01;
    step();
    for (int t = 1; t <= 4; t++) begin
      tk = 1'b1;
      step();
      chk("age_tick", 32'(i4.aged), t >= AGE ? 32'h2 : 32'h0);
    end
    floor(1); dr = 2'b00; arr = 1'b1;
    step();
    step();
    chk("age_clear", 32'(i4.aged), 32'h0);
    us[1] = 1'b1;
    step();
    for (int t = 1; t <= AGE; t++) begin
      tk = 1'b1;
      step();
      chk("age_restart", 32'(i4.aged), t == AGE ? 32'h2 : 32'h0);
    end
    serve_all();
    // random traffic
    for (int n = 0; n < 400; n++) begin
      cs = 5'($urandom) & 5'($urandom);
      us = 5'($urandom) & 5'($urandom);
      ds = 5'($urandom) & 5'($urandom);
      cc = 5'($urandom) & 5'($urandom) & 5'($urandom);
      cf4 = 2'($urandom);
      cf5 = 3'($urandom);
      dr = 2'($urandom);
      arr = $urandom_range(0, 2) == 0;
      tk = 1'($urandom);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/call_request_board.md
Name: call_request_board

Overview:
- Multi-class, parametrised request latch board for the elevator controller.
- Holds car calls, hall-up calls and hall-down calls per floor.
- Clears calls automatically when the car is serviced at a floor, with direction qualification.
- Provides directional summaries and per-floor aging flags to the dispatch FSM.
- Sits between the debounced button inputs and the elevator motion controller.

Parameters:
- N_FLOORS, 4, number of floors (≥2).
- AGE_MAX, 15, saturation value of the per-floor hall-call age counter (≥1).
- FLOOR_W, $clog2(N_FLOORS), floor index width; derived localparam, not overridable.
- CNT_W, $clog2(3*N_FLOORS+1), pending-count width; derived localparam.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- car_set  in  N_FLOORS  one-cycle pulses; set car call for floor i.
- up_set  in  N_FLOORS  pulses; set hall-up call.
- dn_set  in  N_FLOORS  pulses; set hall-down call.
- car_cancel  in  N_FLOORS  pulses; cancel car call for floor i.
- cur_floor  in  FLOOR_W  current car floor.
- dir  in  2  travel direction: 00 idle, 01 up, 10 down, 11 treated as idle.
- arrive  in  1  pulse; car stopped at cur_floor and doors opening.
- age_tick  in  1  aging prescaler strobe.
- car_req  out  N_FLOORS  latched car calls.
- up_req  out  N_FLOORS  latched hall-up calls.
- dn_req  out  N_FLOORS  latched hall-down calls.
- any_above  out  1  any call at a floor > cur_floor.
- any_below  out  1  any call at a floor < cur_floor.
- any_at  out  1  any call at cur_floor.
- pending_cnt  out  CNT_W  total number of latched calls.
- aged  out  N_FLOORS  hall call at floor i has waited AGE_MAX ticks.

Behaviour:
- Reset (rst_n low, asynchronous): car_req, up_req, dn_req, all age counters, aged and pending_cnt are 0. Therefore any_above, any_below and any_at are 0.
- Latency: a set pulse at edge k shows on *_req after edge k (one-cycle latency). pending_cnt is registered and updates on the same edge as *_req.
- any_above, any_below and any_at are combinational from the registered *_req bits and cur_floor.
- Per-bit priority each cycle: service-clear > car_cancel > set > hold.
- Service-clear applies only when arrive=1 and cur_floor < N_FLOORS, at floor f=cur_floor:
  - car_req[f] is always cleared.
  - up_req[f] is cleared when dir is up or idle.
  - dn_req[f] is cleared when dir is down or idle.
- A set pulse at f in the same cycle as a qualifying service-clear is dropped; the call is served immediately.
- A set pulse for a class not qualified by the service-clear latches normally. Example: dir=up, arrive at f, dn_set[f] → dn_req[f]=1.
- car_cancel affects car_req only. Cancel of an unset bit has no effect.
- Physical boundaries:
  - up_set[N_FLOORS-1] is ignored.
  - dn_set[0] is ignored.
  - The corresponding req bits are constant 0.
- cur_floor ≥ N_FLOORS (out of range): arrive is ignored; any_at=0; any_above = any call latched; any_below=0.
- Aging, per floor i, with hall = up_req[i] | dn_req[i]:
  - If hall=0, the counter is reset to 0 on the next edge.
  - Else, on age_tick, the counter increments and saturates at AGE_MAX.
  - aged[i] is registered and equals (counter==AGE_MAX) & hall.
  - Clearing the hall call zeroes the counter and drops aged[i] on the next edge.
  - A new call restarts aging from 0.
- pending_cnt = popcount(next car_req, up_req, dn_req), registered.
- Multiple simultaneous sets on different floors and classes latch independently within one cycle.

Decomposition:
- Package elev_pkg:
  - Direction encoding constants DIR_IDLE=2'b00, DIR_UP=2'b01, DIR_DN=2'b10.
  - Call-class enum CLS_CAR, CLS_UP, CLS_DN.
- Sub-module req_age_counter (parameter AGE_MAX):
  - Inputs clk, rst_n, active, tick.
  - Output aged.
  - One instance per floor via generate.
- The request latching, service-clear and summary logic stay in call_request_board.

Test Plan:
- Reset mid-operation: latch car_set=4'b1010, then pull rst_n low between clock edges → all outputs 0 immediately, without waiting for a clock edge.
- Set/service: N=4, car_set[2], up_set[1]; next cycle cur_floor=0, dir=up → car_req=0100, up_req=0010, any_above=1, pending_cnt=2. Then cur_floor=1, arrive → up_req=0000, car_req unchanged, pending_cnt=1.
- Direction qualification: up_req[2]=1, dn_req[2]=1; cur_floor=2, dir=down, arrive → dn_req[2]=0, up_req[2]=1. Repeat with dir=idle → both cleared.
- Same-cycle collision: cur_floor=3, dir=idle, arrive together with car_set[3] and dn_set[3] → car_req[3]=0, dn_req[3]=0. Separately, car_cancel[1] with car_set[1] in the same cycle → car_req[1]=0.
- Boundaries: up_set[3] and dn_set[0] → no change, pending_cnt=0. cur_floor=5 (FLOOR_W=2 is not possible, so run this with N=5 or force the value), arrive with calls at 0 and 2 → nothing cleared, any_above=1, any_at=0.
- Aging: AGE_MAX=3; up_set[1], then 3 age_tick pulses → aged[1]=1 on the edge after the 3rd tick, stays 1 on a 4th tick. Serve floor 1 → aged[1]=0 next edge; new up_set[1] needs 3 fresh ticks.
